calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Program-driven initiator for the queue calculator's command interface (in/op/apply in, tail/empty/valid out).
- Holds a small instruction memory that the host loads. On start, it clears the calculator, then issues instructions one at a time. After each instruction it waits a fixed settle time, samples valid/tail, and stops on the first error.
- Sits between the host/test logic and the calculator top.

Parameters:
- DEPTH, 16, instruction memory entries
- AW, 4, address width, log2(DEPTH)
- SETTLE, 2, cycles spent in WAIT after each apply before sampling calculator outputs (legal range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- prog_we  in  1  write instruction memory (honoured only when busy=0)
- prog_addr  in  AW  write address
- prog_data  in  11  instruction word {op[2:0], imm[7:0]}
- prog_len  in  AW+1  number of instructions to run, sampled on start; values >DEPTH are clamped to DEPTH
- start  in  1  begin run (honoured only when busy=0)
- abort  in  1  cancel run
- calc_in  out  8  to calculator in
- calc_op  out  3  to calculator op
- calc_apply  out  1  to calculator apply; one-cycle pulse
- calc_clear  out  1  to calculator rst; one-cycle pulse
- calc_tail  in  8  from calculator tail
- calc_empty  in  1  from calculator empty
- calc_valid  in  1  from calculator valid
- busy  out  1  run in progress
- done  out  1  last run completed without error; level
- error  out  1  last run stopped on invalid; level
- err_pc  out  AW  index of the failing instruction
- result  out  8  calc_tail captured at the last successful CHECK
- result_empty  out  1  calc_empty captured with result

Behaviour:
- Reset values: all outputs 0, state IDLE, pc 0. Memory contents are not reset.
- Memory read is combinational from the register array. A write on the same cycle as a read returns the old word.
- States:
  - IDLE/DONE/ERROR: outputs hold. busy=0.
    - start with prog_len=0: done=1, error=0, result unchanged, next state DONE.
    - start otherwise: latch len, pc=0, done=0, error=0, go to CLEAR.
  - CLEAR: calc_clear=1 for exactly one cycle, then ISSUE.
  - ISSUE: calc_in=mem[pc].imm, calc_op=mem[pc].op, calc_apply=1 for one cycle. Load wait counter = SETTLE, go to WAIT.
  - WAIT: decrement the counter; calc_in/op hold their values, calc_apply=0. At 1, go to CHECK.
  - CHECK: sample calc_valid.
    - calc_valid=0: error=1, err_pc=pc, go to ERROR. result is unchanged.
    - calc_valid=1: result=calc_tail, result_empty=calc_empty.
      - pc==len-1: done=1, go to DONE.
      - otherwise: pc++, go to ISSUE.
- busy=1 in CLEAR, ISSUE, WAIT and CHECK.
- Per-instruction latency: 1 (ISSUE) + SETTLE (WAIT) + 1 (CHECK) cycles. Run latency = 1 + len*(SETTLE+2) cycles from start acceptance to done rising.
- abort has priority over all transitions. In any busy state, the next state is IDLE with busy=0, done=0, error=0. No apply or clear is issued on the abort cycle. abort while idle is ignored.
- start and prog_we while busy=1 are ignored. Simultaneous start and prog_we while idle: the write lands and the run starts; the new word is visible from the first ISSUE.
- Asynchronous reset mid-run: return immediately to reset values. calc_clear=0 during reset (the calculator shares rst).
- Clamp: prog_len=DEPTH+k runs DEPTH instructions. pc never wraps.

Test Plan:
- Bench responder stub: registers calc_in into tail on apply; valid=0 latched once op==3'b111 is seen; empty=0 after any apply; stub state cleared by calc_clear.
- Load 3 words (op=0, imm 0x05/0x0A/0x0F), prog_len=3, SETTLE=2, start → calc_clear pulse, 3 apply pulses spaced 4 cycles apart; done rises 13 cycles after start acceptance; result=0x0F, error=0.
- Word 1 op=3'b111, prog_len=3 → two applies only; error=1, err_pc=1, result=0x05, done=0, busy=0.
- prog_len=0 start → no calc_clear, no apply, done=1 next cycle.
- abort asserted in the second WAIT → busy=0 next cycle, no further apply, done=0, error=0. A following start reruns from pc=0, beginning with calc_clear.
- prog_we to address 0 during busy, then rerun → memory unchanged (result as in the first run). start pulsed during busy → no effect on run timing.
- rst asserted mid-WAIT → all outputs 0 immediately. After release, start reruns correctly.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: program-driven initiator for the queue calculator.
// The host loads a small instruction memory; on start the sequencer pulses
// the calculator clear, then issues each instruction, waits a fixed settle
// time, samples valid/tail and stops at the first invalid result.
module calc_sequencer #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [10:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    output logic [7:0]    calc_in,
    output logic [2:0]    calc_op,
    output logic          calc_apply,
    output logic          calc_clear,
    input  logic [7:0]    calc_tail,
    input  logic          calc_empty,
    input  logic          calc_valid,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_pc,
    output logic [7:0]    result,
    output logic          result_empty
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);
    localparam logic [AW:0] DEPTH_LEN  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEN    = (AW+1)'(1);

    // Instruction memory: {op[2:0], imm[7:0]}, not reset.
    logic [10:0] mem [DEPTH];

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    calc_in_q, calc_in_d;
    logic [2:0]    calc_op_q, calc_op_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [AW-1:0] err_pc_q, err_pc_d;
    logic [7:0]    result_q, result_d;
    logic          result_empty_q, result_empty_d;

    logic          idle;
    logic [AW-1:0] pc_inc;
    logic [10:0]   cur_word;
    logic [10:0]   nxt_word;
    logic [AW:0]   len_clamped;
    logic          last_instr;

    assign idle        = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign pc_inc      = pc_q + 1'b1;
    // Combinational reads; writes only happen while idle so no read/write overlap during a run.
    assign cur_word    = mem[pc_q];
    assign nxt_word    = mem[pc_inc];
    assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    assign last_instr  = ({1'b0, pc_q} == (len_q - ONE_LEN));

    // Host writes to the instruction memory, accepted only between runs.
    always_ff @(posedge clk) begin
        if (prog_we && idle) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state and datapath logic; abort overrides every busy-state transition.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        calc_in_d      = calc_in_q;
        calc_op_d      = calc_op_q;
        done_d         = done_q;
        error_d        = error_q;
        err_pc_d       = err_pc_q;
        result_d       = result_q;
        result_empty_d = result_empty_q;

        if (abort && !idle) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        if (len_clamped == '0) begin
                            // Empty program completes immediately without touching the calculator.
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            len_d   = len_clamped;
                            pc_d    = '0;
                            state_d = S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    // pc is already 0 here; present word 0 on the ISSUE cycle.
                    calc_in_d = cur_word[7:0];
                    calc_op_d = cur_word[10:8];
                    state_d   = S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_d   = SETTLE_CNT;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!calc_valid) begin
                        error_d  = 1'b1;
                        err_pc_d = pc_q;
                        state_d  = S_ERROR;
                    end else begin
                        result_d       = calc_tail;
                        result_empty_d = calc_empty;
                        if (last_instr) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            pc_d      = pc_inc;
                            calc_in_d = nxt_word[7:0];
                            calc_op_d = nxt_word[10:8];
                            state_d   = S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            calc_in_q      <= '0;
            calc_op_q      <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_pc_q       <= '0;
            result_q       <= '0;
            result_empty_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            calc_in_q      <= calc_in_d;
            calc_op_q      <= calc_op_d;
            done_q         <= done_d;
            error_q        <= error_d;
            err_pc_q       <= err_pc_d;
            result_q       <= result_d;
            result_empty_q <= result_empty_d;
        end
    end

    // Pulses are gated by abort so nothing reaches the calculator on an abort cycle.
    assign calc_apply   = (state_q == S_ISSUE) && !abort;
    assign calc_clear   = (state_q == S_CLEAR) && !abort;
    assign calc_in      = calc_in_q;
    assign calc_op      = calc_op_q;
    assign busy         = !idle;
    assign done         = done_q;
    assign error        = error_q;
    assign err_pc       = err_pc_q;
    assign result       = result_q;
    assign result_empty = result_empty_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: calculator responder stub, cycle-level
// behavioural model with a per-cycle compare, directed scenarios with
// hand-computed expectations, and randomized runs.
module tb_calc_sequencer;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int SETTLE = 2;
    localparam int PER    = SETTLE + 2;
    localparam int LIMIT  = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [10:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    logic [7:0]    calc_in;
    logic [2:0]    calc_op;
    logic          calc_apply;
    logic          calc_clear;
    logic [7:0]    calc_tail;
    logic          calc_empty;
    logic          calc_valid;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_pc;
    logic [7:0]    result;
    logic          result_empty;

    always #5 clk = ~clk;

    calc_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
        .start(start), .abort(abort),
        .calc_in(calc_in), .calc_op(calc_op), .calc_apply(calc_apply), .calc_clear(calc_clear),
        .calc_tail(calc_tail), .calc_empty(calc_empty), .calc_valid(calc_valid),
        .busy(busy), .done(done), .error(error), .err_pc(err_pc),
        .result(result), .result_empty(result_empty)
    );

    // Calculator responder stub
    logic [7:0] stub_tail;
    logic       stub_valid;
    logic       stub_empty;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_tail <= 8'h00; stub_valid <= 1'b1; stub_empty <= 1'b1;
        end else if (calc_clear) begin
            stub_tail <= 8'h00; stub_valid <= 1'b1; stub_empty <= 1'b1;
        end else if (calc_apply) begin
            stub_tail  <= calc_in;
            stub_empty <= 1'b0;
            if (calc_op == 3'b111) stub_valid <= 1'b0;
        end
    end
    assign calc_tail  = stub_tail;
    assign calc_valid = stub_valid;
    assign calc_empty = stub_empty;

    // Behavioural model state
    logic [10:0] mem_m [DEPTH];
    bit          m_run    = 0;
    int          m_t      = 0;
    int          m_len    = 0;
    logic        m_done   = 0;
    logic        m_error  = 0;
    logic [3:0]  m_err_pc = 0;
    logic [7:0]  m_result = 0;
    logic        m_rempty = 0;
    logic [7:0]  m_in     = 0;
    logic [2:0]  m_op     = 0;
    int          run_id   = 0;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_apply      = 0;
    int n_clear      = 0;

    // Per-cycle compare against the model, then advance the model on the inputs the next edge samples.
    always @(negedge clk) begin
        logic [28:0] exp_v;
        logic [28:0] act_v;
        int          k;
        int          ph;
        int          len;
        logic        e_apply;
        logic        e_clear;
        act_v   = {busy, done, error, err_pc, result, result_empty, calc_in, calc_op, calc_apply, calc_clear};
        n_apply = n_apply + int'(calc_apply);
        n_clear = n_clear + int'(calc_clear);
        k = 0; ph = 0; e_apply = 1'b0; e_clear = 1'b0;
        if (rst) begin
            m_run = 0; m_t = 0; m_done = 0; m_error = 0; m_err_pc = 0;
            m_result = 0; m_rempty = 0; m_in = 0; m_op = 0;
            exp_v = '0;
        end else begin
            if (m_run) begin
                if (m_t == 1) begin
                    e_clear = !abort;
                end else begin
                    k  = (m_t - 2) / PER;
                    ph = (m_t - 2) % PER;
                    if (ph == 0) begin
                        m_in    = mem_m[k][7:0];
                        m_op    = mem_m[k][10:8];
                        e_apply = !abort;
                    end
                end
            end
            exp_v = {m_run, m_done, m_error, m_err_pc, m_result, m_rempty, m_in, m_op, e_apply, e_clear};
        end
        tests_run++;
        if (act_v !== exp_v) begin
            tests_failed++;
            $display("FAIL cycle_outputs t=%0t got=%h expected=%h {busy,done,error,err_pc,result,rempty,in,op,apply,clear}",
                     $time, act_v, exp_v);
        end
        if (!rst) begin
            if (m_run) begin
                if (abort) begin
                    m_run = 0; m_done = 0; m_error = 0;
                    $display("[TB] run %0d aborted at step %0d", run_id, m_t);
                end else if (m_t >= 2 && ph == PER - 1) begin
                    if (mem_m[k][10:8] == 3'b111) begin
                        m_error = 1; m_err_pc = k[3:0]; m_run = 0;
                        $display("[TB] run %0d stopped on invalid at pc %0d", run_id, k);
                    end else begin
                        m_result = mem_m[k][7:0];
                        m_rempty = 1'b0;
                        if (k == m_len - 1) begin
                            m_done = 1; m_run = 0;
                            $display("[TB] run %0d completed %0d instructions, result %h", run_id, m_len, m_result);
                        end else begin
                            m_t++;
                        end
                    end
                end else begin
                    m_t++;
                end
            end else begin
                if (prog_we) mem_m[prog_addr] = prog_data;
                if (start) begin
                    run_id++;
                    len = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
                    m_done = 0; m_error = 0;
                    if (len == 0) begin
                        m_done = 1;
                        $display("[TB] run %0d empty program", run_id);
                    end else begin
                        m_run = 1; m_t = 1; m_len = len;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic write_word(input int addr, input logic [10:0] w);
        prog_we   = 1'b1;
        prog_addr = addr[AW-1:0];
        prog_data = w;
        tick();
        prog_we   = 1'b0;
    endtask

    // Start a run, optionally inject one event at iteration inj_at
    // (1 abort, 2 write while busy, 3 start while busy, 4 reset), return edges until busy drops.
    task automatic run(input int len, input int inj_at, input int kind,
                       input bit sw_en, input int sw_addr, input logic [10:0] sw_data,
                       output int lat);
        int it;
        n_apply  = 0;
        n_clear  = 0;
        prog_len = len[AW:0];
        start    = 1'b1;
        if (sw_en) begin
            prog_we = 1'b1; prog_addr = sw_addr[AW-1:0]; prog_data = sw_data;
        end
        tick();
        start = 1'b0; prog_we = 1'b0;
        lat = 0; it = 0;
        while (busy && lat < LIMIT) begin
            if (it == inj_at) begin
                case (kind)
                    1: abort = 1'b1;
                    2: begin prog_we = 1'b1; prog_addr = '0; prog_data = {3'b111, 8'hAA}; end
                    3: start = 1'b1;
                    4: begin
                        rst = 1'b1;
                        #1;
                        check("reset_outputs_zero",
                              int'({busy, done, error, err_pc, result, result_empty, calc_in, calc_op, calc_apply, calc_clear}), 0);
                    end
                    default: ;
                endcase
            end
            tick();
            abort = 1'b0; prog_we = 1'b0; start = 1'b0; rst = 1'b0;
            lat++; it++;
        end
        check("run_terminates", int'(busy), 0);
    endtask

    initial begin
        int lat;
        logic [10:0] w;
        logic [2:0]  op;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("reset_state",
              int'({busy, done, error, err_pc, result, result_empty, calc_in, calc_op, calc_apply, calc_clear}), 0);
        rst = 1'b0;
        tick();

        // Load every word so nothing is undefined, then the three-word program.
        for (int i = 0; i < DEPTH; i++) write_word(i, {3'b000, 8'(8'h10 + i)});
        write_word(0, {3'b000, 8'h05});
        write_word(1, {3'b000, 8'h0A});
        write_word(2, {3'b000, 8'h0F});

        // Basic three-instruction run
        run(3, -1, 0, 0, 0, 0, lat);
        check("basic_latency", lat, 13);
        check("basic_applies", n_apply, 3);
        check("basic_clears", n_clear, 1);
        check("basic_result", int'(result), 8'h0F);
        check("basic_done", int'(done), 1);
        check("basic_error", int'(error), 0);

        // Invalid at word 1
        write_word(1, {3'b111, 8'h0A});
        run(3, -1, 0, 0, 0, 0, lat);
        check("err_latency", lat, 9);
        check("err_applies", n_apply, 2);
        check("err_flag", int'(error), 1);
        check("err_pc", int'(err_pc), 1);
        check("err_result", int'(result), 8'h05);
        check("err_done", int'(done), 0);

        // Empty program
        run(0, -1, 0, 0, 0, 0, lat);
        check("len0_latency", lat, 0);
        check("len0_done", int'(done), 1);
        check("len0_error", int'(error), 0);
        check("len0_clears", n_clear, 0);
        check("len0_applies", n_apply, 0);
        check("len0_result", int'(result), 8'h05);

        // Abort in the second instruction's WAIT, then rerun
        write_word(1, {3'b000, 8'h0A});
        run(3, 6, 1, 0, 0, 0, lat);
        repeat (5) tick();
        check("abort_applies", n_apply, 2);
        check("abort_done", int'(done), 0);
        check("abort_error", int'(error), 0);
        check("abort_busy", int'(busy), 0);
        run(3, -1, 0, 0, 0, 0, lat);
        check("rerun_clears", n_clear, 1);
        check("rerun_applies", n_apply, 3);
        check("rerun_latency", lat, 13);
        check("rerun_result", int'(result), 8'h0F);

        // Write and start while busy are ignored
        run(3, 3, 2, 0, 0, 0, lat);
        check("busy_we_latency", lat, 13);
        run(3, -1, 0, 0, 0, 0, lat);
        check("busy_we_result", int'(result), 8'h0F);
        check("busy_we_error", int'(error), 0);
        run(3, 5, 3, 0, 0, 0, lat);
        check("busy_start_latency", lat, 13);
        check("busy_start_applies", n_apply, 3);

        // Reset during the first WAIT, then rerun
        run(3, 2, 4, 0, 0, 0, lat);
        check("rst_applies", n_apply, 1);
        run(3, -1, 0, 0, 0, 0, lat);
        check("post_rst_latency", lat, 13);
        check("post_rst_result", int'(result), 8'h0F);

        // Length clamp: 20 runs all 16 words
        run(20, -1, 0, 0, 0, 0, lat);
        check("clamp_applies", n_apply, 16);
        check("clamp_latency", lat, 65);
        check("clamp_result", int'(result), 8'h1F);

        // Write on the start cycle is visible to the run
        run(3, -1, 0, 1, 2, {3'b000, 8'h33}, lat);
        check("sim_we_result", int'(result), 8'h33);

        // Abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("idle_abort_done", int'(done), 1);

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int j = 0; j < nw; j++) begin
                op = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
                w  = {op, 8'($urandom_range(0, 255))};
                write_word($urandom_range(0, DEPTH - 1), w);
            end
            begin
                int len;
                int kind;
                len  = $urandom_range(0, 20);
                kind = $urandom_range(0, 3);
                op   = 3'($urandom_range(0, 6));
                run(len, $urandom_range(0, len * PER + 2), kind,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH - 1),
                    {op, 8'($urandom_range(0, 255))}, lat);
            end
            if ($urandom_range(0, 3) == 0) abort = 1'b1;
            tick();
            abort = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
